// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, bit timing, checker
// strobes and the accept/reject decision for each frame.
module uart_rx_ctrl #(
  parameter int Data_Width = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_nstate;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_ncnt;
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] w_chk;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_nbit;
  logic                  r_par_en;

  logic w_bit_end;
  logic w_lat;
  logic w_last;
  logic w_glitch;
  logic w_err;

  logic r_glt;
  logic r_par_stk;
  logic r_stp_stk;
  logic r_fin;

  logic r_samp;
  logic r_strt;
  logic r_deser;
  logic r_par;
  logic r_stp;
  logic r_dv;
  logic r_fe;
  logic r_busy;

  logic w_busy_n;
  logic w_strt_n;
  logic w_deser_n;
  logic w_par_n;
  logic w_stp_n;
  logic w_fin_n;
  logic w_dv_n;
  logic w_fe_n;

  assign w_chk     = (r_pre >> 1) + PRESCALE_W'(2);
  assign w_bit_end = r_cnt == (r_pre - PRESCALE_W'(1));
  assign w_last    = r_bit == BW'(Data_Width - 1);

  // checker results arrive the cycle after the strobe
  assign w_lat     = r_cnt == (w_chk + PRESCALE_W'(1));
  assign w_glitch  = r_glt | (w_lat & strt_glitch);
  assign w_err     = (r_par_en & r_par_stk) | r_stp_stk;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_pre    <= '0;
      r_par_en <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_bit   <= w_nbit;
      if (r_state == S_IDLE && !RX_IN) begin
        r_pre    <= Prescale;
        r_par_en <= PAR_EN;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nbit   = r_bit;
    w_ncnt   = '0;
    if (r_state != S_IDLE) begin
      w_ncnt = w_bit_end ? '0 : r_cnt + PRESCALE_W'(1);
    end
    unique case (r_state)
      S_IDLE: begin
        w_nbit = '0;
        if (!RX_IN) w_nstate = S_START;
      end
      S_START: begin
        if (w_bit_end) begin
          w_nbit   = '0;
          w_nstate = w_glitch ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (w_last) begin
            w_nbit   = '0;
            w_nstate = r_par_en ? S_PAR : S_STOP;
          end else begin
            w_nbit = r_bit + BW'(1);
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) w_nstate = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) w_nstate = S_IDLE;
      end
      default: begin
        w_nstate = S_IDLE;
        w_nbit   = '0;
        w_ncnt   = '0;
      end
    endcase
  end

  // strobes look one cycle ahead so they are high while edge_cnt==CHK
  always_comb begin
    w_busy_n  = w_nstate != S_IDLE;
    w_strt_n  = (w_nstate == S_START) && (w_ncnt == w_chk);
    w_deser_n = (w_nstate == S_DATA)  && (w_ncnt == w_chk);
    w_par_n   = (w_nstate == S_PAR)   && (w_ncnt == w_chk);
    w_stp_n   = (w_nstate == S_STOP)  && (w_ncnt == w_chk);
    w_fin_n   = (r_state == S_STOP) && w_bit_end;
    w_dv_n    = r_fin && !w_err;
    w_fe_n    = r_fin && w_err;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_samp    <= 1'b0;
      r_strt    <= 1'b0;
      r_deser   <= 1'b0;
      r_par     <= 1'b0;
      r_stp     <= 1'b0;
      r_dv      <= 1'b0;
      r_fe      <= 1'b0;
      r_busy    <= 1'b0;
      r_fin     <= 1'b0;
      r_glt     <= 1'b0;
      r_par_stk <= 1'b0;
      r_stp_stk <= 1'b0;
    end else begin
      r_samp  <= w_busy_n;
      r_busy  <= w_busy_n;
      r_strt  <= w_strt_n;
      r_deser <= w_deser_n;
      r_par   <= w_par_n;
      r_stp   <= w_stp_n;
      r_dv    <= w_dv_n;
      r_fe    <= w_fe_n;
      r_fin   <= w_fin_n;
      r_glt   <= (r_state == S_START) &&
                 (w_nstate == S_START) && w_glitch;
      if (r_fin) begin
        r_par_stk <= 1'b0;
        r_stp_stk <= 1'b0;
      end else begin
        if (r_state == S_PAR && w_lat && par_err)
          r_par_stk <= 1'b1;
        if (r_state == S_STOP && w_lat && stp_err)
          r_stp_stk <= 1'b1;
      end
    end
  end

  assign dat_samp_en = r_samp;
  assign strt_chk_en = r_strt;
  assign deser_en    = r_deser;
  assign par_chk_en  = r_par;
  assign stp_chk_en  = r_stp;
  assign data_valid  = r_dv;
  assign frame_err   = r_fe;
  assign busy        = r_busy;

endmodule
